aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Sequencer for AES-128 key expansion. It drives the existing 32-bit g-function block (rotate, S-box, round-constant XOR; round index 1..10 as input) for one round per cycle. Each expanded round key goes into an 11-entry round-key store. The encryption round controller reads round keys through a registered read port after a start/done handshake.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported; store depth is NR+1.
KEY_W, 128, cipher key and round-key width in bits.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request expansion of key_in; sampled only in IDLE
key_in  input  128  cipher key; w0 = key_in[127:96], w3 = key_in[31:0]; sampled on accepted start
busy  output  1  high while in LOAD or EXPAND
done  output  1  one-cycle pulse when round key 10 is stored
key_ready  output  1  high when store holds a complete schedule for the last accepted key
rd_idx  input  4  round-key index 0..10
rd_key  output  128  registered round key for rd_idx, 1-cycle latency

Behaviour:
- States: IDLE, LOAD, EXPAND, FIN. Reset: state=IDLE, round=0, busy=0, done=0, key_ready=0, rd_key=0.
- IDLE -> LOAD on start=1. In that cycle, key_in is latched into store[0] and key_ready is cleared.
- LOAD (1 cycle): round<=1, then go to EXPAND.
- EXPAND, each cycle:
  - prev = store[round-1]; g = g-function(prev[31:0], round).
  - n0 = prev[127:96]^g, n1 = prev[95:64]^n0, n2 = prev[63:32]^n1, n3 = prev[31:0]^n2.
  - store[round] <= {n0,n1,n2,n3}.
  - If round==10: go to FIN. Otherwise round<=round+1.
- FIN (1 cycle): done=1, key_ready<=1, busy=0, then go to IDLE.
- Latency: start accepted at cycle T. store[1] is written at the end of T+2, store[10] at the end of T+11. done is high in cycle T+12.
- start outside IDLE is ignored; no queueing. A start in the same cycle done is high is also ignored. It is accepted the next cycle.
- The round counter never wraps; it is 4 bits and saturates at 10 by construction.
- Reads:
  - rd_key <= store[rd_idx] every cycle, in any state.
  - rd_idx 11..15 returns 128'h0.
  - Reading an index during EXPAND returns whatever the store holds at that clock edge. Validity is guaranteed only when key_ready=1.
- rst mid-expansion: back to IDLE next edge, busy=0, key_ready=0, no done pulse. Store contents are left untouched unless the option below is enabled.
- A write and a read of the same index in one cycle return the old value (read-before-write).

Optional Feature:
Macro AES_KEYSCHED_ZEROIZE_EN.
- Defined: on rst and on every accepted start, store[1..10] is cleared to zero in that cycle. store[0] takes key_in on start and is zeroed on rst. Not-yet-written rounds read 0.
- Undefined: no clearing; stale round keys from the prior schedule remain readable until overwritten.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_NR=10 and AES_KEY_W=128;
  - the state enum type (IDLE/LOAD/EXPAND/FIN);
  - typedef round_key_t (128-bit).
- Reuse the existing g-function module, one instance.
- One natural new sub-module, aes_rk_store: 11x128 register array with one write port, one registered read port, optional zeroize.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle:
  - done exactly 12 cycles after start;
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605;
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rd_idx=0 -> the key itself.
- Start held high across the whole expansion with a second key -> ignored while busy. Exactly one done pulse. Store matches the first key only.
- Assert rst at cycle T+6 of an expansion -> busy=0 and key_ready=0 next cycle, no done. A fresh start then yields the correct FIPS-197 schedule.
- Key all-zero -> rd_idx=1 = 62636363626363636263636362636363; rd_idx=10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- rd_idx=11 and rd_idx=15 -> rd_key=0. Index change to data change is exactly 1 cycle.
- With AES_KEYSCHED_ZEROIZE_EN: after a completed schedule, start a new key and read rd_idx=9 at T+3 -> 0. Without the macro -> the previous schedule's round-9 key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule slice.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        FIN    = 2'd3
    } ks_state_t;

    typedef logic [AES_KEY_W-1:0] round_key_t;

    // Round constant for AES-128 rounds 1..10; any other index yields zero.
    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] rc;
        unique case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_g_func.sv
// AES key-expansion g-function: RotWord, SubWord, then XOR with Rcon(round).
module aes_g_func
    import aes_pkg::*;
(
    input  logic [31:0] word,
    input  logic [3:0]  round,
    output logic [31:0] g
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [31:0] rot;
    logic [31:0] sub;

    always_comb begin
        rot = {word[23:0], word[31:24]};
        sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        g   = sub ^ {aes_rcon(round), 24'h000000};
    end

endmodule

// File: rtl/aes_rk_store.sv
// Round-key store: one write port, one registered read-before-write read port.
// Optional clearing of the expanded rounds under AES_KEYSCHED_ZEROIZE_EN.
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int DEPTH = AES_NR + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] wr_idx,
    input  round_key_t wr_key,
    input  logic       clr,
    input  logic [3:0] rd_idx,
    output round_key_t rd_key
);

    round_key_t mem [DEPTH];

    // Reads sample mem before this edge's write lands, so same-index access returns the old key.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key <= '0;
        end else if (int'(rd_idx) < DEPTH) begin
            rd_key <= mem[rd_idx];
        end else begin
            rd_key <= '0;
        end
    end

`ifdef AES_KEYSCHED_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr) begin
                for (int i = 1; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
            if (we && int'(wr_idx) < DEPTH) begin
                mem[wr_idx] <= wr_key;
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;

    always_ff @(posedge clk) begin
        if (!rst && we && int'(wr_idx) < DEPTH) begin
            mem[wr_idx] <= wr_key;
        end
    end
`endif

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: one round key per cycle into aes_rk_store.
// Build option AES_KEYSCHED_ZEROIZE_EN clears stale round keys on reset and on start.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             key_ready,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    // state  | meaning
    // IDLE   | waiting for start; start latches key_in into store[0]
    // LOAD   | one-cycle setup, round counter primed to 1
    // EXPAND | one round key derived and stored per cycle, rounds 1..NR
    // FIN    | done pulse; key_ready raised at the end of this cycle

    ks_state_t  state;
    logic [3:0] round;
    round_key_t prev;
    logic [31:0] g_word;
    logic [31:0] n0, n1, n2, n3;
    round_key_t next_key;

    logic       start_acc;
    logic       st_we;
    logic [3:0] st_wr_idx;
    round_key_t st_wr_key;

    // prev mirrors store[round-1] so expansion needs no second read port on the store.
    aes_g_func u_g_func (
        .word  (prev[31:0]),
        .round (round),
        .g     (g_word)
    );

    always_comb begin
        n0       = prev[127:96] ^ g_word;
        n1       = prev[95:64]  ^ n0;
        n2       = prev[63:32]  ^ n1;
        n3       = prev[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        start_acc = (state == IDLE) && start;
        st_we     = start_acc || (state == EXPAND);
        st_wr_idx = start_acc ? 4'd0 : round;
        st_wr_key = start_acc ? round_key_t'(key_in) : next_key;
    end

    aes_rk_store #(
        .DEPTH (NR + 1)
    ) u_rk_store (
        .clk    (clk),
        .rst    (rst),
        .we     (st_we),
        .wr_idx (st_wr_idx),
        .wr_key (st_wr_key),
        .clr    (start_acc),
        .rd_idx (rd_idx),
        .rd_key (rd_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round     <= 4'd0;
            prev      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= LOAD;
                        prev      <= key_in;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    round <= 4'd1;
                    state <= EXPAND;
                end
                EXPAND: begin
                    prev <= next_key;
                    if (round == 4'(NR)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    key_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl; expected round keys come from FIPS-197 vectors.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_q [$];

    aes_key_sched_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_ready (key_ready),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present start with key for one rising edge; returns at that edge (end of cycle T).
    task automatic do_start(input logic [127:0] key);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
    endtask

    // Watches done for a bounded window; cycle numbers are relative to the accepting edge.
    task automatic wait_done(input int base, input bit hold, output int first_cyc, output int pulses);
        first_cyc = 0;
        pulses    = 0;
        for (int cyc = base + 1; cyc <= base + 25; cyc++) begin
            @(negedge clk);
            if (!hold && cyc == 1) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_cyc == 0) first_cyc = cyc;
                if (hold) start = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        rd_idx = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, key_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, key_ready});
        end
        checks++;
        if (rd_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_rd_key got=%h want=0", rd_key);
        end
        rst = 1'b0;
    endtask

    task automatic test_fips;
        int first_cyc, pulses;
        logic [3:0]   idx_tbl [3];
        logic [127:0] exp_tbl [3];
        logic [127:0] got, exp;
        idx_tbl = '{4'd1, 4'd10, 4'd0};
        exp_tbl = '{FIPS_R1, FIPS_R10, FIPS_KEY};
        do_start(FIPS_KEY);
        wait_done(0, 1'b0, first_cyc, pulses);
        checks++;
        if (first_cyc != 12 || pulses != 1) begin
            errors++;
            $display("FAIL fips_done_latency got=%0d pulses=%0d want=12 pulses=1", first_cyc, pulses);
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL fips_key_ready got=%b want=1", key_ready);
        end
        for (int i = 0; i < 3; i++) begin
            rd_idx = idx_tbl[i];
            exp_q.push_back(exp_tbl[i]);
            @(negedge clk);
            got = rd_key;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fips_rd_idx%0d got=%h want=%h", idx_tbl[i], got, exp);
            end
        end
    endtask

    task automatic test_oob_read;
        logic [3:0]   idx_tbl [4];
        logic [127:0] exp_tbl [4];
        logic [127:0] got, exp, last;
        idx_tbl = '{4'd11, 4'd10, 4'd15, 4'd1};
        exp_tbl = '{128'h0, FIPS_R10, 128'h0, FIPS_R1};
        last = FIPS_KEY;
        for (int i = 0; i < 4; i++) begin
            rd_idx = idx_tbl[i];
            exp_q.push_back(exp_tbl[i]);
            #1;
            checks++;
            if (rd_key !== last) begin
                errors++;
                $display("FAIL oob_no_comb_path idx=%0d got=%h want=%h", idx_tbl[i], rd_key, last);
            end
            @(negedge clk);
            got = rd_key;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL oob_rd_idx%0d got=%h want=%h", idx_tbl[i], got, exp);
            end
            last = exp;
        end
    endtask

    task automatic test_stale_and_zero_key;
        int first_cyc, pulses;
        logic [3:0]   idx_tbl [3];
        logic [127:0] exp_tbl [3];
        logic [127:0] got, exp;
        idx_tbl = '{4'd1, 4'd10, 4'd0};
        exp_tbl = '{ZERO_R1, ZERO_R10, ZERO_KEY};
        @(negedge clk);
        rd_idx = 4'd9;
`ifdef AES_KEYSCHED_ZEROIZE_EN
        exp_q.push_back(128'h0);
`else
        exp_q.push_back(FIPS_R9);
`endif
        do_start(ZERO_KEY);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        got = rd_key;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stale_rd_idx9 got=%h want=%h", got, exp);
        end
        wait_done(3, 1'b0, first_cyc, pulses);
        checks++;
        if (first_cyc != 12 || pulses != 1) begin
            errors++;
            $display("FAIL zero_done_latency got=%0d pulses=%0d want=12 pulses=1", first_cyc, pulses);
        end
        for (int i = 0; i < 3; i++) begin
            rd_idx = idx_tbl[i];
            exp_q.push_back(exp_tbl[i]);
            @(negedge clk);
            got = rd_key;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_rd_idx%0d got=%h want=%h", idx_tbl[i], got, exp);
            end
        end
    endtask

    task automatic test_back_to_back_start;
        int first_cyc, pulses;
        logic [3:0]   idx_tbl [3];
        logic [127:0] exp_tbl [3];
        logic [127:0] got, exp;
        idx_tbl = '{4'd10, 4'd1, 4'd0};
        exp_tbl = '{FIPS_R10, FIPS_R1, FIPS_KEY};
        do_start(FIPS_KEY);
        @(negedge clk);
        key_in = ZERO_KEY;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_busy got=%b want=1", busy);
        end
        wait_done(1, 1'b1, first_cyc, pulses);
        checks++;
        if (first_cyc != 12 || pulses != 1) begin
            errors++;
            $display("FAIL hold_done got=%0d pulses=%0d want=12 pulses=1", first_cyc, pulses);
        end
        for (int i = 0; i < 3; i++) begin
            rd_idx = idx_tbl[i];
            exp_q.push_back(exp_tbl[i]);
            @(negedge clk);
            got = rd_key;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_rd_idx%0d got=%h want=%h", idx_tbl[i], got, exp);
            end
        end
    endtask

    task automatic test_rst_mid;
        int first_cyc, pulses;
        int seen_done;
        logic [127:0] got, exp;
        do_start(ZERO_KEY);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, key_ready, done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_flags got=%b want=000", {busy, key_ready, done});
        end
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got=%0d want=0", seen_done);
        end
        do_start(FIPS_KEY);
        wait_done(0, 1'b0, first_cyc, pulses);
        checks++;
        if (first_cyc != 12 || pulses != 1) begin
            errors++;
            $display("FAIL rst_restart_done got=%0d pulses=%0d want=12 pulses=1", first_cyc, pulses);
        end
        rd_idx = 4'd10;
        exp_q.push_back(FIPS_R10);
        @(negedge clk);
        got = rd_key;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rst_restart_rd_idx10 got=%h want=%h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_oob_read();
        test_stale_and_zero_key();
        test_back_to_back_start();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
